// File: rtl/uart_rx_axis.sv
// UART receiver (8N1-style, 16x oversampling, majority-of-3 sampling) delivering
// each good word as a single AXI-Stream beat with frame-error and overrun pulses.
module uart_rx_axis #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_wire,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned OSR_DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int unsigned DIV_W   = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
  localparam int unsigned BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  if (OSR_DIV < 1) begin : g_div_check
    $error("uart_rx_axis: CLK_FREQ too low for 16x oversampling of BAUD_RATE");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [3:0]            samp_q, samp_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  s7_q, s7_d, s8_q, s8_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  busy_q, busy_d;

  logic                  tick_c, maj_c, good_c;

  // Two-flop synchronizer; idle-high line so both flops reset to 1
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_wire;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      samp_q   <= '0;
      bit_q    <= '0;
      s7_q     <= 1'b0;
      s8_q     <= 1'b0;
      shift_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      samp_q   <= samp_d;
      bit_q    <= bit_d;
      s7_q     <= s7_d;
      s8_q     <= s8_d;
      shift_q  <= shift_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state, sampling and stream-output logic
  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    bit_d    = bit_q;
    s7_d     = s7_q;
    s8_d     = s8_q;
    shift_d  = shift_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    good_c   = 1'b0;

    tick_c = (div_q == DIV_W'(OSR_DIV - 1));
    div_d  = tick_c ? '0 : DIV_W'(div_q + DIV_W'(1));
    maj_c  = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);

    if (tick_c && (state_q != IDLE)) begin
      samp_d = samp_q + 4'd1;
      if (samp_q == 4'd7) s7_d = rx_s_q;
      if (samp_q == 4'd8) s8_d = rx_s_q;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          div_d   = '0;
          samp_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (tick_c) begin
          if ((samp_q == 4'd9) && maj_c) begin
            state_d = IDLE;
          end else if (samp_q == 4'd15) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (tick_c) begin
          if (samp_q == 4'd9) shift_d = DATA_WIDTH'({maj_c, shift_q} >> 1);
          if (samp_q == 4'd15) begin
            if (bit_q == BIT_W'(DATA_WIDTH - 1)) state_d = STOP;
            else                                 bit_d   = BIT_W'(bit_q + BIT_W'(1));
          end
        end
      end
      STOP: begin
        // Decide at the mid-bit sample and leave at once for early resync
        if (tick_c && (samp_q == 4'd9)) begin
          state_d = IDLE;
          if (maj_c) good_c = 1'b1;
          else       ferr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A completing word may refill the slot in the same cycle it is drained
    if (good_c) begin
      if (!tvalid_q || m_axis_tready) begin
        tdata_d  = shift_q;
        tvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign frame_err     = ferr_q;
  assign overrun       = ovr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Scoreboard bench for uart_rx_axis: frames are driven bit-serially at the default
// baud rate, expected beats/pulses come from a frame-level model of the receiver.
module tb_uart_rx_axis;

  localparam int unsigned BIT = 432;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_wire;
  logic       tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_axis dut (
    .clk          (clk),
    .rst          (rst),
    .rx_wire      (rx_wire),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(tready),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         cyc       = 0;
  int         start_cyc = 0;
  logic [7:0] exp_q[$];
  int         exp_ferr  = 0;
  int         exp_ovr   = 0;
  int         ferr_seen = 0;
  int         ovr_seen  = 0;
  logic       tvalid_prev = 1'b0;
  logic       ferr_prev   = 1'b0;
  logic       ovr_prev    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Frame-level model: what the sink should eventually see for one frame
  task automatic expect_frame(input logic [7:0] d, input logic stop_b);
    if (!stop_b)                            exp_ferr++;
    else if (!tready && exp_q.size() != 0)  exp_ovr++;
    else                                    exp_q.push_back(d);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    @(negedge clk);
    start_cyc = cyc;
    rx_wire = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_wire = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx_wire = stop_b;
    repeat (BIT) @(negedge clk);
    rx_wire = 1'b1;
  endtask

  task automatic send_checked(input logic [7:0] d, input logic stop_b);
    expect_frame(d, stop_b);
    send_frame(d, stop_b);
  endtask

  task automatic checkpoint(input string tag);
    check({tag, "_frame_err_count"}, ferr_seen, exp_ferr);
    check({tag, "_overrun_count"}, ovr_seen, exp_ovr);
    check({tag, "_pending_beats"}, exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every handshake, tracks pulses and latency
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && !tvalid_prev)
        check("tvalid_latency_in_window",
              int'((cyc - start_cyc) >= 4000 && (cyc - start_cyc) <= 4300), 1);
      if (m_axis_tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got tdata 0x%0h, want no beat (cycle %0d)",
                   m_axis_tdata, cyc);
        end else begin
          check("beat_tdata", int'(m_axis_tdata), int'(exp_q.pop_front()));
        end
      end
      if (frame_err) begin
        ferr_seen++;
        check("frame_err_one_cycle", int'(ferr_prev), 0);
      end
      if (overrun) begin
        ovr_seen++;
        check("overrun_one_cycle", int'(ovr_prev), 0);
      end
    end
    tvalid_prev = m_axis_tvalid;
    ferr_prev   = frame_err;
    ovr_prev    = overrun;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, int'(m_axis_tvalid), 0);
    check({tag, "_tdata"}, int'(m_axis_tdata), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    logic [7:0] base;
    rst     = 1'b1;
    rx_wire = 1'b1;
    tready  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single good frame
    send_checked(8'hA5, 1'b1);
    checkpoint("a5");

    // Short low glitch is rejected in START
    rx_wire = 1'b0;
    repeat (50) @(negedge clk);
    check("glitch_busy_during", int'(busy), 1);
    repeat (50) @(negedge clk);
    rx_wire = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_busy_after", int'(busy), 0);
    check("glitch_no_tvalid", int'(m_axis_tvalid), 0);
    checkpoint("glitch");

    // Bad stop bit, then recovery
    send_checked(8'h3C, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    check("ferr_busy_after_gap", int'(busy), 0);
    check("ferr_no_tvalid", int'(m_axis_tvalid), 0);
    send_checked(8'h55, 1'b1);
    checkpoint("ferr");

    // Sink stalled: second word is dropped with overrun
    tready = 1'b0;
    send_checked(8'h11, 1'b1);
    send_checked(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    check("stall_tvalid", int'(m_axis_tvalid), 1);
    check("stall_tdata_held", int'(m_axis_tdata), 8'h11);
    check("stall_overrun_count", ovr_seen, exp_ovr);
    tready = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("stall_tvalid_cleared", int'(m_axis_tvalid), 0);
    checkpoint("stall");

    // Back-to-back frames
    send_checked(8'h00, 1'b1);
    send_checked(8'hFF, 1'b1);
    send_checked(8'h80, 1'b1);
    checkpoint("b2b");

    // Reset during data bit 4; remaining bits of 0xF0 are ones, so no false start
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (5 * BIT + BIT / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midframe_reset");
        rst = 1'b0;
      end
    join
    repeat (BIT) @(negedge clk);
    check("post_reset_idle", int'(busy), 0);
    send_checked(8'h96, 1'b1);
    checkpoint("reset");

    // Incrementing sequence from a random base
    base = 8'($urandom_range(0, 255));
    for (int k = 0; k < 4; k++) send_checked(8'(base + 8'(k)), 1'b1);
    repeat (10) @(negedge clk);
    checkpoint("incr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis.md
UART_RX_AXIS -- requirements
Module: uart_rx_axis

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, the line bit rate.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, the data bits per frame (no parity, 1 stop bit).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port rx_wire, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port m_axis_tdata, output, DATA_WIDTH bits: the received word.
REQ-008 SHALL have port m_axis_tvalid, output, 1 bit: the word is valid.
REQ-009 SHALL have port m_axis_tready, input, 1 bit: the sink accepts the word.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-011 SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed word is dropped.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 SHALL pass rx_wire through a 2-flop synchronizer (both flops reset to 1); all decoding uses the synchronized value rx_s.
REQ-014 SHALL derive OSR_DIV = CLK_FREQ/(BAUD_RATE*16) by integer division (27 at defaults), and SHALL require OSR_DIV >= 1.
REQ-015 SHALL run a divider counter 0..OSR_DIV-1; tick is high for the one cycle in which the count equals OSR_DIV-1.
REQ-016 SHALL clear the divider to 0 on the IDLE->START transition, so that bit phase aligns to the start edge.
REQ-017 SHALL count ticks 0..15 per bit in a sample counter; samples are taken at ticks 7, 8 and 9, and the bit value is the majority of the three.
REQ-018 SHALL use states IDLE, START, DATA and STOP.
REQ-019 IDLE: SHALL go to START when rx_s==0, clearing the sample counter and the bit index.
REQ-020 START: SHALL return to IDLE at tick 9 if the majority is 1 (glitch rejection, no pulses); SHALL otherwise go to DATA after tick 15.
REQ-021 DATA: SHALL shift the majority bits in LSB first; after tick 15 of bit DATA_WIDTH-1 SHALL go to STOP; the bit index wraps only by leaving DATA.
REQ-022 STOP: SHALL decide at tick 9 and then go straight to IDLE without waiting for ticks 10-15, so that resync is early.
REQ-023 STOP majority 1: SHALL present the word on m_axis_tdata with m_axis_tvalid high in the next cycle (latency 1 clk from the decision).
REQ-024 STOP majority 0: SHALL pulse frame_err for 1 cycle, discard the word and leave m_axis unchanged.
REQ-025 SHALL hold m_axis_tvalid and m_axis_tdata stable until m_axis_tvalid && m_axis_tready; tvalid SHALL not depend combinationally on tready.
REQ-026 Completion while tvalid=1 and tready=0: SHALL keep the old word, drop the new one and pulse overrun.
REQ-027 Completion in the same cycle as a handshake: the new word SHALL replace the old one, tvalid SHALL stay 1 and overrun SHALL not pulse.
REQ-028 A handshake with no completion SHALL clear tvalid in the next cycle.
REQ-029 SHALL start no new frame detection until the FSM is back in IDLE; a low line in IDLE after an error SHALL be treated as a new start.

Reset
REQ-030 rst high SHALL force, on the next edge: state IDLE, counters 0, shift register 0, synchronizer flops 1, m_axis_tdata 0, m_axis_tvalid 0, frame_err 0, overrun 0, busy 0.
REQ-031 Reset mid-frame SHALL discard the partial word and produce no pulse; after rst falls, reception SHALL resume at the next falling edge.

Verification (defaults; bit = 432 clk)
REQ-032 Send 0xA5 with a correct frame, tready=1 -> exactly one beat with tdata=0xA5, tvalid high about 9.5 bit periods (~4104 clk) after the start edge; frame_err=0.
REQ-033 Hold rx_wire low for 100 clk, then high -> FSM returns to IDLE, no tvalid, no frame_err.
REQ-034 Send 0x3C with the stop bit driven 0 -> frame_err pulses once, tvalid stays 0; a following correct 0x55 frame is received as 0x55.
REQ-035 tready=0; send 0x11 then 0x22 -> tdata stays 0x11 with tvalid high, overrun pulses once at the second stop; raising tready accepts 0x11 and no 0x22 is delivered.
REQ-036 Back-to-back frames 0x00, 0xFF, 0x80 with tready=1 -> three beats in order, no errors; a loopback from the team uart transmitter yields an incrementing sequence.
REQ-037 Assert rst for 2 clk during bit 4 of a frame -> outputs go to their reset values, no beat, and the next full frame is received correctly.
